warp_issue_scheduler: RTL
=========================

# warp_issue_scheduler

Parametrised successor of the single-issue warp scheduler. It selects one ready warp per cycle, with unit-aware masking, and builds a dispatch request for the request FIFO. In the same cycle it tells the scoreboard which destination the issued instruction will write. New relative to the first generation: warp count, instruction and predicate widths are generic; a greedy-then-round-robin mode; a holding output register that sustains back-to-back issue; illegal-instruction filtering; an issue counter.

## Interface
- NUM_WARPS, 32: warp slots, power of two, 2..64
- INSTR_W, 63: instruction-buffer entry width; rd = [INSTR_W-1 -: 5], flags = [7:0]
- PRED_W, 32: per-warp predicate mask width
- WID_W, $clog2(NUM_WARPS): warp id width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- sched_mode  in  1  0 = round-robin, 1 = greedy-then-round-robin (GTRR)
- warp_ready_mask  in  NUM_WARPS  warp eligible by the scoreboard
- instruction_buffer  in  NUM_WARPS x INSTR_W  head instruction per warp
- pred  in  NUM_WARPS x PRED_W  predicate mask per warp
- m_tready_alu / m_tready_lsu / m_tready_special  in  1  unit can accept
- m_tvalid_ib_sb  out  1  one-cycle scoreboard notify pulse
- target_warp  out  WID_W  issued warp
- target_gpr_out  out  5  {1, rd[3:0]} when rd<16, else 0
- target_unir_out  out  4  {1, rd[2:0]} when 16<=rd<24, else 0
- target_is_pc / target_is_pred  out  1  flags[2] / flags[4]
- m_tvalid_request_fifo  out  1  dispatch request valid, held until accepted
- m_tready_request_fifo  in  1  FIFO accepts
- dispatch_request  out  WID_W+INSTR_W+PRED_W+3  {warp_id, instr, pred, v_alu, v_lsu, v_special}
- err  out  32  error code; 0 = none
- issue_count  out  32  instructions issued since reset, wraps

## Operation
- Unit class comes from flags[1:0]:
  - 00: special
  - 01: alu
  - 10: lsu
  - 11: illegal
- Eligible[i] requires all of:
  - warp_ready_mask[i]
  - class ≠ illegal
  - the class's m_tready is high
- Illegal warps never issue. While any ready warp holds an illegal instruction, err = ERR_BOTH_UNITS_USED. Otherwise err = 0.
- Round-robin: first eligible warp scanning upward from last_idx+1 mod NUM_WARPS.
- GTRR: if warp last_idx is eligible it is chosen again; otherwise use the round-robin rule.
- can_load = !m_tvalid_request_fifo || m_tready_request_fifo.
- Issue occurs when can_load and any warp is eligible. On issue:
  - load dispatch_request with exactly one v_* bit set
  - set m_tvalid_request_fifo
  - update last_idx
  - pulse m_tvalid_ib_sb with the target_* fields
  - increment issue_count
- Scoreboard contract: the scoreboard clears warp_ready_mask for the issued warp combinationally in the cycle after the m_tvalid_ib_sb pulse. Until it does, the warp stays eligible.
- If can_load is high and no warp is eligible, m_tvalid_request_fifo falls once the current request is accepted.

## Timing
- Reset, asynchronous:
  - all outputs 0
  - last_idx = NUM_WARPS-1, so the first round-robin pick starts at warp 0
  - issue_count = 0
- Reset mid-transfer drops the held request. It is not replayed.
- Latency: inputs sampled at edge N appear on the outputs after edge N.
- Throughput: one issue per cycle while the FIFO stays ready, with no bubble.
- FIFO stall: dispatch_request and m_tvalid_request_fifo hold stable and m_tvalid_ib_sb stays 0.
- Simultaneous accept and new issue in the same cycle: the new request replaces the old. Valid stays high.
- target_* fields hold their last values when m_tvalid_ib_sb = 0.
- issue_count wraps from 0xFFFF_FFFF to 0.

## Structure
- Shared package common: error-code constants ERR_NONE and ERR_BOTH_UNITS_USED, the unit-class enum, and flag bit positions (ALU=0, LSU=1, PC=2, PRED=4).
- Sub-module rr_arbiter #(N): request vector plus last index in, one-hot grant and index out, purely combinational with a rotate/priority/unrotate structure. GTRR override logic stays in the top.

## Test plan
- Reset, all 32 warps ready, all alu, FIFO always ready, mode 0 → warps 0,1,2,…,31,0 on consecutive cycles; issue_count = 33 after 33 cycles.
- Mode 1, warps 3 and 9 ready → warp 3 issues every cycle. Drop warp 3 → warp 9 issues next cycle.
- Warp 5 lsu, m_tready_lsu = 0, warp 6 alu → warp 6 issues, v_alu = 1. Warp 5 issues only after m_tready_lsu rises.
- FIFO stalls for 4 cycles with a request held → dispatch_request constant, no m_tvalid_ib_sb pulse. On ready, the next warp issues the same cycle the old request is accepted.
- rd = 7 → target_gpr_out = 0x17; rd = 18 → target_unir_out = 0xA; rd = 30 → both 0. flags = 0x14 → target_is_pc = 1, target_is_pred = 1.
- Warp 2 flags[1:0] = 11 and ready, alone → no issue and err = ERR_BOTH_UNITS_USED. Assert rst_n low mid-stall → all outputs 0 immediately.

Source files
------------

// File: rtl/warp_issue_scheduler_pkg.sv
// rtl/warp_issue_scheduler_pkg.sv - shared constants, unit-class enum and flag decode
package warp_issue_scheduler_pkg;

  localparam logic [31:0] ERR_NONE            = 32'h0000_0000;
  localparam logic [31:0] ERR_BOTH_UNITS_USED = 32'h0000_0001;

  // Flag bit positions inside the low byte of an instruction
  localparam int FLAG_ALU  = 0;
  localparam int FLAG_LSU  = 1;
  localparam int FLAG_PC   = 2;
  localparam int FLAG_PRED = 4;

  typedef enum logic [1:0] {
    UC_SPECIAL = 2'b00,
    UC_ALU     = 2'b01,
    UC_LSU     = 2'b10,
    UC_ILLEGAL = 2'b11
  } unit_class_e;

  // Unit class is the {LSU, ALU} flag pair
  function automatic unit_class_e unit_class(input logic [1:0] cls_bits);
    return unit_class_e'(cls_bits);
  endfunction

endpackage

// File: rtl/warp_issue_scheduler_if.sv
// rtl/warp_issue_scheduler_if.sv - dispatch request stream and scoreboard notify bundle
interface warp_issue_scheduler_if #(
  parameter int NUM_WARPS = 32,
  parameter int INSTR_W   = 63,
  parameter int PRED_W    = 32,
  parameter int WID_W     = $clog2(NUM_WARPS)
);
  localparam int DREQ_W = WID_W + INSTR_W + PRED_W + 3;

  logic              m_tvalid_ib_sb;
  logic [WID_W-1:0]  target_warp;
  logic [4:0]        target_gpr_out;
  logic [3:0]        target_unir_out;
  logic              target_is_pc;
  logic              target_is_pred;
  logic              m_tvalid_request_fifo;
  logic              m_tready_request_fifo;
  logic [DREQ_W-1:0] dispatch_request;

  modport master (
    output m_tvalid_ib_sb, target_warp, target_gpr_out, target_unir_out,
           target_is_pc, target_is_pred, m_tvalid_request_fifo, dispatch_request,
    input  m_tready_request_fifo
  );

  modport slave (
    input  m_tvalid_ib_sb, target_warp, target_gpr_out, target_unir_out,
           target_is_pc, target_is_pred, m_tvalid_request_fifo, dispatch_request,
    output m_tready_request_fifo
  );
endinterface

// File: rtl/warp_issue_scheduler_rr_arbiter.sv
// rtl/warp_issue_scheduler_rr_arbiter.sv - combinational round-robin arbiter (rotate/priority/unrotate)
module warp_issue_scheduler_rr_arbiter #(
  parameter int N  = 32,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_idx,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [IW-1:0] start;
  logic [N-1:0]  rotated;
  logic [IW-1:0] rot_idx;

  // Search starts just after the last winner; N is a power of two so wrap is free
  assign start = last_idx + 1'b1;

  // Rotate so that the start position lands on bit 0
  always_comb begin
    rotated = '0;
    for (int i = 0; i < N; i++) begin
      rotated[i] = req[IW'(i) + start];
    end
  end

  // Lowest set bit of the rotated vector wins
  always_comb begin
    rot_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) rot_idx = IW'(i);
    end
  end

  assign grant_valid = |req;
  assign grant_idx   = rot_idx + start;
  assign grant       = grant_valid ? (ONE << grant_idx) : '0;

endmodule

// File: rtl/warp_issue_scheduler.sv
// rtl/warp_issue_scheduler.sv - single-issue warp scheduler with RR/GTRR selection and held dispatch request
module warp_issue_scheduler
  import warp_issue_scheduler_pkg::*;
#(
  parameter int NUM_WARPS = 32,
  parameter int INSTR_W   = 63,
  parameter int PRED_W    = 32,
  parameter int WID_W     = $clog2(NUM_WARPS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              sched_mode,
  input  logic [NUM_WARPS-1:0]              warp_ready_mask,
  input  logic [NUM_WARPS-1:0][INSTR_W-1:0] instruction_buffer,
  input  logic [NUM_WARPS-1:0][PRED_W-1:0]  pred,
  input  logic                              m_tready_alu,
  input  logic                              m_tready_lsu,
  input  logic                              m_tready_special,
  warp_issue_scheduler_if.master            bus,
  output logic [31:0]                       err,
  output logic [31:0]                       issue_count
);
  localparam int DREQ_W = WID_W + INSTR_W + PRED_W + 3;
  localparam logic [NUM_WARPS-1:0] ONE = {{(NUM_WARPS-1){1'b0}}, 1'b1};

  logic [NUM_WARPS-1:0] eligible, illegal_ready;
  logic [NUM_WARPS-1:0] arb_grant, sel_onehot;
  logic [WID_W-1:0]     arb_idx, sel_idx;
  logic                 arb_valid, gtrr_hit, can_load, issue;
  logic [INSTR_W-1:0]   sel_instr;
  logic [PRED_W-1:0]    sel_pred;
  logic [4:0]           sel_rd;
  unit_class_e          sel_cls;

  logic              req_valid_q, req_valid_d;
  logic [DREQ_W-1:0] dispatch_q, dispatch_d;
  logic              sb_valid_q, sb_valid_d;
  logic [WID_W-1:0]  target_warp_q, target_warp_d;
  logic [4:0]        target_gpr_q, target_gpr_d;
  logic [3:0]        target_unir_q, target_unir_d;
  logic              target_is_pc_q, target_is_pc_d;
  logic              target_is_pred_q, target_is_pred_d;
  logic [WID_W-1:0]  last_idx_q, last_idx_d;
  logic [31:0]       issue_count_q, issue_count_d;
  logic [31:0]       err_q, err_d;

  // Per-warp eligibility: ready, legal class, and the class's unit can accept
  always_comb begin
    eligible      = '0;
    illegal_ready = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      case (unit_class(instruction_buffer[i][1:0]))
        UC_ALU:     eligible[i] = warp_ready_mask[i] & m_tready_alu;
        UC_LSU:     eligible[i] = warp_ready_mask[i] & m_tready_lsu;
        UC_SPECIAL: eligible[i] = warp_ready_mask[i] & m_tready_special;
        default:    illegal_ready[i] = warp_ready_mask[i];
      endcase
    end
  end

  warp_issue_scheduler_rr_arbiter #(.N(NUM_WARPS), .IW(WID_W)) u_arb (
    .req         (eligible),
    .last_idx    (last_idx_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // GTRR override keeps the last warp while it stays eligible; then mux its entry
  always_comb begin
    gtrr_hit   = sched_mode & eligible[last_idx_q];
    sel_onehot = gtrr_hit ? (ONE << last_idx_q) : arb_grant;
    sel_idx    = gtrr_hit ? last_idx_q : arb_idx;
    sel_instr  = '0;
    sel_pred   = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      sel_instr = sel_instr | (instruction_buffer[i] & {INSTR_W{sel_onehot[i]}});
      sel_pred  = sel_pred  | (pred[i] & {PRED_W{sel_onehot[i]}});
    end
    sel_rd  = sel_instr[INSTR_W-1 -: 5];
    sel_cls = unit_class(sel_instr[1:0]);
  end

  assign can_load = ~req_valid_q | bus.m_tready_request_fifo;
  assign issue    = can_load & arb_valid;

  // Next-state: load a fresh request on issue, drop valid once accepted with nothing new
  always_comb begin
    req_valid_d      = req_valid_q;
    dispatch_d       = dispatch_q;
    sb_valid_d       = 1'b0;
    target_warp_d    = target_warp_q;
    target_gpr_d     = target_gpr_q;
    target_unir_d    = target_unir_q;
    target_is_pc_d   = target_is_pc_q;
    target_is_pred_d = target_is_pred_q;
    last_idx_d       = last_idx_q;
    issue_count_d    = issue_count_q;
    err_d            = (|illegal_ready) ? ERR_BOTH_UNITS_USED : ERR_NONE;
    if (issue) begin
      req_valid_d      = 1'b1;
      dispatch_d       = {sel_idx, sel_instr, sel_pred,
                          sel_cls == UC_ALU, sel_cls == UC_LSU, sel_cls == UC_SPECIAL};
      sb_valid_d       = 1'b1;
      target_warp_d    = sel_idx;
      target_gpr_d     = (sel_rd < 5'd16) ? {1'b1, sel_rd[3:0]} : 5'd0;
      target_unir_d    = (sel_rd[4:3] == 2'b10) ? {1'b1, sel_rd[2:0]} : 4'd0;
      target_is_pc_d   = sel_instr[FLAG_PC];
      target_is_pred_d = sel_instr[FLAG_PRED];
      last_idx_d       = sel_idx;
      issue_count_d    = issue_count_q + 32'd1;
    end else if (can_load) begin
      req_valid_d = 1'b0;
    end
  end

  // State registers; reset clears outputs and points RR so warp 0 is tried first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid_q      <= 1'b0;
      dispatch_q       <= '0;
      sb_valid_q       <= 1'b0;
      target_warp_q    <= '0;
      target_gpr_q     <= '0;
      target_unir_q    <= '0;
      target_is_pc_q   <= 1'b0;
      target_is_pred_q <= 1'b0;
      last_idx_q       <= WID_W'(NUM_WARPS - 1);
      issue_count_q    <= '0;
      err_q            <= '0;
    end else begin
      req_valid_q      <= req_valid_d;
      dispatch_q       <= dispatch_d;
      sb_valid_q       <= sb_valid_d;
      target_warp_q    <= target_warp_d;
      target_gpr_q     <= target_gpr_d;
      target_unir_q    <= target_unir_d;
      target_is_pc_q   <= target_is_pc_d;
      target_is_pred_q <= target_is_pred_d;
      last_idx_q       <= last_idx_d;
      issue_count_q    <= issue_count_d;
      err_q            <= err_d;
    end
  end

  assign bus.m_tvalid_request_fifo = req_valid_q;
  assign bus.dispatch_request      = dispatch_q;
  assign bus.m_tvalid_ib_sb        = sb_valid_q;
  assign bus.target_warp           = target_warp_q;
  assign bus.target_gpr_out        = target_gpr_q;
  assign bus.target_unir_out       = target_unir_q;
  assign bus.target_is_pc          = target_is_pc_q;
  assign bus.target_is_pred        = target_is_pred_q;
  assign err                       = err_q;
  assign issue_count               = issue_count_q;

endmodule
